ub_multibank: RTL and testbench
===============================

# ub_multibank

Parametrised N-bank ping-pong unified buffer for the TPU datapath, generalising the two-bank buffer to NUM_BANKS banks in a rotating ring. One bank is the read bank and the next bank in the ring is the write bank. Independent burst read and burst write engines have valid/ready handshakes and read back-pressure. Bank rotation is an explicit, handshaked swap that is applied only when both engines are idle. The block sits between the host/DMA write path and the systolic-array operand feed.

## Interface
- DATA_WIDTH, 256, bits per entry.
- DEPTH, 128, entries per bank; power of two, ≥ 2.
- NUM_BANKS, 2, number of banks; power of two, ≥ 2.
- ADDR_WIDTH, $clog2(DEPTH), in-bank address width.
- BANK_WIDTH, $clog2(NUM_BANKS), bank pointer width.
- CNT_WIDTH, ADDR_WIDTH+1, burst count width.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- swap_req  in  1  single-cycle pulse; request ring rotation.
- swap_done  out  1  pulse on the cycle the rotation is applied.
- rd_bank  out  BANK_WIDTH  current read bank. The write bank is (rd_bank+1) mod NUM_BANKS.
- rd_start  in  1  start a read burst.
- rd_addr  in  ADDR_WIDTH  read burst start address.
- rd_count  in  CNT_WIDTH  number of read beats.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts the current beat.
- rd_busy  out  1  read engine is not idle.
- rd_done  out  1  pulse when the last read beat is accepted.
- wr_start  in  1  start a write burst.
- wr_addr  in  ADDR_WIDTH  write burst start address.
- wr_count  in  CNT_WIDTH  number of write beats.
- wr_data  in  DATA_WIDTH  write data.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  block accepts a write beat.
- wr_busy  out  1  write engine is not idle.
- wr_done  out  1  pulse when the last write beat is written.
- cmd_err  out  1  pulse when a start command is rejected.
- rd_beats  out  32  read beats accepted since reset.
- wr_beats  out  32  write beats written since reset.

## Operation
Read engine states:
- R_IDLE --rd_start & rd_count≠0--> R_BURST. Latches addr, latches count as remaining.
- R_BURST: issue one BRAM read when the output register is empty or is being consumed (!rd_valid | rd_ready). Each issue: addr+1 mod DEPTH, remaining−1. After the last issue --> R_DRAIN.
- R_DRAIN: hold the final beat until rd_valid & rd_ready. Then pulse rd_done and go --> R_IDLE.

Write engine states:
- W_IDLE --wr_start & wr_count≠0--> W_BURST.
- W_BURST: wr_ready=1. Each wr_valid & wr_ready writes wr_data to the write bank at addr, then addr+1 mod DEPTH, remaining−1. The last beat pulses wr_done and goes --> W_IDLE.

Command and swap rules:
- Rejected starts: a start while that engine is busy, or a start with count 0, is ignored and pulses cmd_err. Simultaneous rd_start and wr_start are independent.
- Swap: swap_req sets a pending flag. The swap is applied on the first cycle with both engines idle and no start asserted that cycle. Applying it does rd_bank <= rd_bank+1 and pulses swap_done. A second swap_req while one is pending is merged into it (one rotation only).
- Start vs pending swap: a start on the cycle a swap could apply wins, and the swap waits.
- Bank isolation: reads and writes always target different banks, so there is no address collision.
- Address wrap: an address wraps modulo DEPTH within its bank and never crosses a bank boundary.

## Timing
- Reset values: rd_valid, rd_busy, rd_done, wr_ready, wr_busy, wr_done, cmd_err, swap_done = 0; rd_bank = 0; rd_data = 0; counters = 0. Memory contents are not cleared.
- Reset mid-burst: both engines go to idle and the pending swap is cleared.
- Start to first beat: rd_start at cycle T gives first rd_valid at T+2. wr_start at T gives wr_ready at T+1.
- Read throughput: one beat per cycle while rd_ready=1. With rd_ready=0, rd_data and rd_valid hold stable and no new reads are issued.
- Busy flags: rd_busy and wr_busy are high from the cycle after the accepted start through the done cycle, inclusive.
- Swap latency: with both engines idle, swap_req at T gives swap_done and the new rd_bank at T+1.

## Configuration
- UB_STATS_EN defined: rd_beats and wr_beats are saturating 32-bit counters. rd_beats counts rd_valid & rd_ready. wr_beats counts accepted write beats.
- UB_STATS_EN undefined: both outputs are tied to 0 and no counter logic is synthesised.

## Test plan
- Write/read across a swap: write 4 beats 0xA0..0xA3 to bank 1 at addr 5, swap, read 4 at addr 5 with rd_ready=1 -> rd_bank=1; data 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after rd_start; rd_done on the last beat.
- Read back-pressure: drop rd_ready for 3 cycles mid-burst -> rd_data held; no beat lost or duplicated; rd_beats=4.
- Write wrap: write burst with addr=DEPTH−2, count 4 -> entries DEPTH−2, DEPTH−1, 0, 1 written in the same bank.
- Rejected commands: rd_start with count=0; wr_start during an active write -> cmd_err pulse each time; state unchanged.
- Deferred swap: swap_req during a read burst -> swap_done only after rd_done, on the first cycle with both engines idle; with NUM_BANKS=4, four swaps return rd_bank to 0.
- Reset mid-burst: assert rst_n=0 during a write burst -> all outputs at reset values next cycle; earlier-written data is still readable afterwards.

Source files
------------

// File: rtl/ub_multibank.sv
// N-bank rotating ping-pong unified buffer with independent burst read/write engines.
// Define UB_STATS_EN to enable saturating beat counters on rd_beats/wr_beats.
module ub_multibank #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned NUM_BANKS  = 2,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BANK_WIDTH = $clog2(NUM_BANKS),
    parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic [BANK_WIDTH-1:0] rd_bank,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [CNT_WIDTH-1:0]  rd_count,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_busy,
    output logic                  rd_done,
    input  logic                  wr_start,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CNT_WIDTH-1:0]  wr_count,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_busy,
    output logic                  wr_done,
    output logic                  cmd_err,
    output logic [31:0]           rd_beats,
    output logic [31:0]           wr_beats
);

    typedef enum logic [1:0] {R_IDLE, R_BURST, R_DRAIN} rd_state_e;
    typedef enum logic       {W_IDLE, W_BURST}          wr_state_e;

    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS*DEPTH];

    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_WIDTH-1:0]  rd_rem_q, rd_rem_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    wr_state_e             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_WIDTH-1:0]  wr_rem_q, wr_rem_d;

    logic [BANK_WIDTH-1:0] bank_q;
    logic                  swap_pend_q, swap_done_q, cmd_err_q;

    logic rd_accept, rd_reject, rd_issue, rd_take;
    logic wr_accept, wr_reject, wr_beat;
    logic swap_apply;
    logic [BANK_WIDTH-1:0]            wr_bank;
    logic [BANK_WIDTH+ADDR_WIDTH-1:0] rd_idx, wr_idx;

    assign rd_accept = rd_start && (rd_state_q == R_IDLE) && (rd_count != '0);
    assign rd_reject = rd_start && !rd_accept;
    assign rd_issue  = (rd_state_q == R_BURST) && (!rd_valid_q || rd_ready);
    assign rd_take   = rd_valid_q && rd_ready;

    assign wr_accept = wr_start && (wr_state_q == W_IDLE) && (wr_count != '0);
    assign wr_reject = wr_start && !wr_accept;
    assign wr_beat   = (wr_state_q == W_BURST) && wr_valid;

    // Bank pointer width wraps naturally since NUM_BANKS is a power of two.
    assign wr_bank = bank_q + BANK_WIDTH'(1);
    assign rd_idx  = {bank_q, rd_addr_q};
    assign wr_idx  = {wr_bank, wr_addr_q};

    assign swap_apply = (swap_pend_q || swap_req) && (rd_state_q == R_IDLE) &&
                        (wr_state_q == W_IDLE) && !rd_start && !wr_start;

    // ---------------- read engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        case (rd_state_q)
            R_IDLE: begin
                if (rd_accept) begin
                    rd_addr_d  = rd_addr;
                    rd_rem_d   = rd_count;
                    rd_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (rd_issue) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_rem_d  = rd_rem_q - CNT_WIDTH'(1);
                    if (rd_rem_q == CNT_WIDTH'(1)) rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (rd_take) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_busy = (rd_state_q != R_IDLE);
        rd_done = (rd_state_q == R_DRAIN) && rd_take;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (rd_issue) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= mem_q[rd_idx];
        end else if (rd_take) begin
            rd_valid_q <= 1'b0;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // ---------------- write engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_rem_q   <= wr_rem_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_addr_d  = wr_addr;
                    wr_rem_d   = wr_count;
                    wr_state_d = W_BURST;
                end
            end
            W_BURST: begin
                if (wr_beat) begin
                    wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    wr_rem_d  = wr_rem_q - CNT_WIDTH'(1);
                    if (wr_rem_q == CNT_WIDTH'(1)) wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (wr_state_q == W_BURST);
        wr_busy  = (wr_state_q == W_BURST);
        wr_done  = wr_beat && (wr_rem_q == CNT_WIDTH'(1));
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_beat) mem_q[wr_idx] <= wr_data;
    end

    // ---------------- swap and command status ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q      <= '0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            swap_done_q <= swap_apply;
            cmd_err_q   <= rd_reject || wr_reject;
            if (swap_apply) begin
                bank_q      <= bank_q + BANK_WIDTH'(1);
                swap_pend_q <= 1'b0;
            end else if (swap_req) begin
                swap_pend_q <= 1'b1;
            end
        end
    end

    assign rd_bank   = bank_q;
    assign swap_done = swap_done_q;
    assign cmd_err   = cmd_err_q;

`ifdef UB_STATS_EN
    logic [31:0] rd_beats_q, wr_beats_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_beats_q <= '0;
            wr_beats_q <= '0;
        end else begin
            if (rd_take && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 32'd1;
            if (wr_beat && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 32'd1;
        end
    end

    assign rd_beats = rd_beats_q;
    assign wr_beats = wr_beats_q;
`else
    assign rd_beats = '0;
    assign wr_beats = '0;
`endif

endmodule

// File: tb/tb_ub_multibank.sv
// Scoreboard bench for ub_multibank: expected read beats queued at rd_start, compared on acceptance.
module tb_ub_multibank;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 16;
    localparam int unsigned NB  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned BW  = 2;
    localparam int unsigned CW  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          swap_req = 1'b0;
    logic          swap_done;
    logic [BW-1:0] rd_bank;
    logic          rd_start = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_count = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          rd_busy;
    logic          rd_done;
    logic          wr_start = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_count = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          wr_busy;
    logic          wr_done;
    logic          cmd_err;
    logic [31:0]   rd_beats;
    logic [31:0]   wr_beats;

    ub_multibank #(
        .DATA_WIDTH(DW),
        .DEPTH(DEP),
        .NUM_BANKS(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .swap_req(swap_req), .swap_done(swap_done), .rd_bank(rd_bank),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_count(rd_count),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_busy(rd_busy), .rd_done(rd_done),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_count(wr_count),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_busy(wr_busy), .wr_done(wr_done),
        .cmd_err(cmd_err), .rd_beats(rd_beats), .wr_beats(wr_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    rd_exp_t       sb[$];
    logic [DW-1:0] model [NB][DEP];
    int            exp_bank = 0;
    int            exp_rd_beats = 0;
    int            exp_wr_beats = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Read-side monitor: compare accepted beats and check data holds under back-pressure.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (hold_pend) check("rd_hold", {32'd0, rd_data}, {32'd0, hold_data});
            hold_pend = (rd_valid === 1'b1) && (rd_ready === 1'b0);
            hold_data = rd_data;
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                exp_rd_beats++;
                if (sb.size() == 0) begin
                    check("rd_extra_beat", 64'd1, 64'd0);
                end else begin
                    rd_exp_t e;
                    e = sb.pop_front();
                    check("rd_data", {32'd0, rd_data}, {32'd0, e.data});
                    check("rd_done", {63'd0, rd_done}, {63'd0, e.last});
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic check_stats();
`ifdef UB_STATS_EN
        check("rd_beats", {32'd0, rd_beats}, 64'(exp_rd_beats));
        check("wr_beats", {32'd0, wr_beats}, 64'(exp_wr_beats));
`else
        check("rd_beats", {32'd0, rd_beats}, 64'd0);
        check("wr_beats", {32'd0, wr_beats}, 64'd0);
`endif
    endtask

    task automatic do_write(input int addr, input int count, input int base);
        int wb;
        wb = (exp_bank + 1) % NB;
        wr_start = 1'b1; wr_addr = AW'(addr); wr_count = CW'(count);
        @(posedge clk); #1;
        wr_start = 1'b0;
        check("wr_ready", {63'd0, wr_ready}, 64'd1);
        for (int i = 0; i < count; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(base + i);
            model[wb][(addr + i) % DEP] = DW'(base + i);
            @(negedge clk);
            check("wr_done", {63'd0, wr_done}, {63'd0, (i == count - 1)});
            @(posedge clk); #1;
            exp_wr_beats++;
        end
        wr_valid = 1'b0;
        check("wr_busy_end", {63'd0, wr_busy}, 64'd0);
    endtask

    task automatic do_read(input int addr, input int count, input int stall_at,
                           input int stall_len, input int swap_at);
        int cyc;
        for (int i = 0; i < count; i++)
            sb.push_back('{data: model[exp_bank][(addr + i) % DEP], last: (i == count - 1)});
        rd_start = 1'b1; rd_addr = AW'(addr); rd_count = CW'(count); rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            rd_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            swap_req = (cyc == swap_at);
            if (cyc == 0) begin
                check("rd_lat0_valid", {63'd0, rd_valid}, 64'd0);
                check("rd_busy", {63'd0, rd_busy}, 64'd1);
            end
            if (cyc == 1) check("rd_lat1_valid", {63'd0, rd_valid}, 64'd1);
            check("swap_held", {63'd0, swap_done}, 64'd0);
            @(posedge clk); #1;
            cyc++;
        end
        swap_req = 1'b0;
        rd_ready = 1'b0;
        check("rd_timeout", 64'(sb.size()), 64'd0);
        check("rd_cycles", 64'(cyc), 64'(count + 1 + stall_len));
        check("rd_busy_end", {63'd0, rd_busy}, 64'd0);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
        exp_bank = (exp_bank + 1) % NB;
        check("swap_done", {63'd0, swap_done}, 64'd1);
        check("rd_bank", {62'd0, rd_bank}, 64'(exp_bank));
    endtask

    task automatic check_reset_values();
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_busy", {63'd0, rd_busy}, 64'd0);
        check("rst_rd_done", {63'd0, rd_done}, 64'd0);
        check("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
        check("rst_wr_busy", {63'd0, wr_busy}, 64'd0);
        check("rst_wr_done", {63'd0, wr_done}, 64'd0);
        check("rst_cmd_err", {63'd0, cmd_err}, 64'd0);
        check("rst_swap_done", {63'd0, swap_done}, 64'd0);
        check("rst_rd_bank", {62'd0, rd_bank}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_rd_beats", {32'd0, rd_beats}, 64'd0);
        check("rst_wr_beats", {32'd0, wr_beats}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write A0..A3 to bank 1, rotate, read back with full throughput.
        do_write(5, 4, 'hA0);
        do_swap();
        do_read(5, 4, -1, 0, -1);
        check_stats();

        // Back-pressure: three stalled cycles mid-burst.
        do_write(0, 6, 'hB0);
        do_read(5, 4, 2, 3, -1);
        check_stats();

        // Rejected read with zero count.
        rd_start = 1'b1; rd_addr = AW'(3); rd_count = '0;
        @(posedge clk); #1;
        rd_start = 1'b0;
        check("rej_rd_err", {63'd0, cmd_err}, 64'd1);
        check("rej_rd_busy", {63'd0, rd_busy}, 64'd0);
        @(posedge clk); #1;
        check("rej_err_clear", {63'd0, cmd_err}, 64'd0);

        // Rejected write start while a 2-beat burst is active.
        wr_start = 1'b1; wr_addr = AW'(8); wr_count = CW'(2);
        @(posedge clk); #1;
        wr_start = 1'b1; wr_addr = AW'(0); wr_count = CW'(3);
        wr_valid = 1'b1; wr_data = DW'('hF0);
        model[(exp_bank + 1) % NB][8] = DW'('hF0);
        @(posedge clk); #1;
        wr_start = 1'b0;
        exp_wr_beats++;
        check("rej_wr_err", {63'd0, cmd_err}, 64'd1);
        wr_data = DW'('hF1);
        model[(exp_bank + 1) % NB][9] = DW'('hF1);
        check("rej_wr_done", {63'd0, wr_done}, 64'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        exp_wr_beats++;
        check("rej_wr_idle", {63'd0, wr_busy}, 64'd0);

        // Wrapping write in bank 2.
        do_write(DEP - 2, 4, 'hC0);

        // Swap requested mid-read waits for the read to finish.
        do_read(5, 4, -1, 0, 1);
        check("swap_wait", {63'd0, swap_done}, 64'd0);
        @(posedge clk); #1;
        exp_bank = (exp_bank + 1) % NB;
        check("swap_deferred", {63'd0, swap_done}, 64'd1);
        check("rd_bank_deferred", {62'd0, rd_bank}, 64'(exp_bank));
        do_read(DEP - 2, 4, -1, 0, -1);
        do_read(8, 2, -1, 0, -1);
        do_read(2, 2, -1, 0, -1);
        check_stats();

        // Rotate to bank 0, then four rotations return to 0.
        do_swap();
        do_swap();
        for (int i = 0; i < 4; i++) do_swap();
        check("ring_wrap", {62'd0, rd_bank}, 64'd0);

        // Reset mid-burst with a swap pending.
        wr_start = 1'b1; wr_addr = AW'(0); wr_count = CW'(4);
        @(posedge clk); #1;
        wr_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'('hE0 + i);
            swap_req = (i == 0);
            model[1][i] = DW'('hE0 + i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        swap_req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values();
        rst_n = 1'b1;
        exp_bank = 0;
        exp_rd_beats = 0;
        exp_wr_beats = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("pend_cleared", {63'd0, swap_done}, 64'd0);
        end
        do_swap();
        do_read(0, 2, -1, 0, -1);
        do_read(5, 4, -1, 0, -1);
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
